fwd_hazard_ctrl: RTL

- Generates the select lines for the EX-stage operand 2:1/3:1 forwarding multiplexers and the pipeline stall for the 5-stage MIPS pipeline.
- Consumes decoded register fields from ID and tracks destination/write info through EX, MEM and WB in internal shadow registers.
- Sits beside the ID/EX pipeline register. Its outputs drive the operand mux sel inputs, the PC/IF-ID write enables and the ID/EX bubble insert.

---
 rtl/fwd_hazard_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage operand forwarding selects and load-use / RAW
// stall generation for a 5-stage MIPS pipeline.
//
// This block keeps shadow copies of the destination and write information
// for EX, MEM and WB. It uses those copies to drive the operand mux selects
// and the pipeline stall.
//
// Build option FWD_HAZARD_FORWARD_EN:
//   defined   - forwarding from EX/MEM and MEM/WB; stall only on load-use
//   undefined - no forwarding (selects tied 00); stall on any RAW hazard
//               against EX or MEM
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Flush,
  input  logic                   IdValid,
  input  logic [REG_ADDR_W-1:0]  IdRs,
  input  logic [REG_ADDR_W-1:0]  IdRt,
  input  logic                   IdUsesRs,
  input  logic                   IdUsesRt,
  input  logic [REG_ADDR_W-1:0]  IdDest,
  input  logic                   IdRegWrite,
  input  logic                   IdMemRead,
  output logic                   Stall,
  output logic [1:0]             FwdSelA,
  output logic [1:0]             FwdSelB,
  output logic                   ExBubble,
  output logic [STALL_CNT_W-1:0] StallCount
);

  // Operand index 0 is Rs (port A), index 1 is Rt (port B).
  logic [1:0][REG_ADDR_W-1:0] id_src;
  logic [1:0]                 id_uses;

  // EX shadow state.
  logic [REG_ADDR_W-1:0]      ex_dest_reg;
  logic                       ex_regwrite_reg;
  logic                       ex_memread_reg;
  logic [1:0][REG_ADDR_W-1:0] ex_src_reg;
  logic [1:0]                 ex_uses_reg;
  logic                       ex_bubble_reg;

  // MEM and WB shadow state.
  logic [REG_ADDR_W-1:0]      mem_dest_reg;
  logic                       mem_regwrite_reg;
  logic [REG_ADDR_W-1:0]      wb_dest_reg;
  logic                       wb_regwrite_reg;

  logic [STALL_CNT_W-1:0]     stall_cnt_reg;

  // Per-operand hazard terms and forwarding selects.
  logic [1:0]                 ex_hit;
  logic [1:0]                 mem_hit;
  logic [1:0][1:0]            fwd_sel;
  logic                       hazard;
  logic                       ex_load_bubble;

  assign id_src  = {IdRt, IdRs};
  assign id_uses = {IdUsesRt, IdUsesRs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      // The ID source matches a nonzero destination that EX or MEM will write.
      assign ex_hit[gi]  = id_uses[gi] & ex_regwrite_reg & (ex_dest_reg != '0)
                           & (ex_dest_reg == id_src[gi]);
      assign mem_hit[gi] = id_uses[gi] & mem_regwrite_reg & (mem_dest_reg != '0)
                           & (mem_dest_reg == id_src[gi]);
`ifdef FWD_HAZARD_FORWARD_EN
      // The younger producer (MEM) wins over the older one (WB).
      assign fwd_sel[gi] =
        (ex_uses_reg[gi] & mem_regwrite_reg & (mem_dest_reg != '0)
         & (mem_dest_reg == ex_src_reg[gi])) ? 2'b01 :
        (ex_uses_reg[gi] & wb_regwrite_reg & (wb_dest_reg != '0)
         & (wb_dest_reg == ex_src_reg[gi])) ? 2'b10 : 2'b00;
`else
      assign fwd_sel[gi] = 2'b00;
`endif
    end
  endgenerate

`ifdef FWD_HAZARD_FORWARD_EN
  // Only a load in EX cannot be forwarded in time to the consumer's EX.
  assign hazard = ex_memread_reg & (|ex_hit);
  logic unused_fwd;
  assign unused_fwd = ^mem_hit;
`else
  // Without forwarding, any pending write in EX or MEM blocks the reader.
  // The register file writes in the first half-cycle, so WB is never a hazard.
  assign hazard = (|ex_hit) | (|mem_hit);
  logic unused_nofwd;
  assign unused_nofwd = ^{ex_memread_reg, ex_src_reg, ex_uses_reg,
                          wb_dest_reg, wb_regwrite_reg};
`endif

  assign Stall          = IdValid & ~Flush & hazard;
  assign ex_load_bubble = Flush | Stall | ~IdValid;
  assign FwdSelA        = fwd_sel[0];
  assign FwdSelB        = fwd_sel[1];
  assign ExBubble       = ex_bubble_reg;
  assign StallCount     = stall_cnt_reg;

  // Advance the shadow pipeline; insert a bubble into EX when ID is not issued.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ex_dest_reg      <= '0;
      ex_regwrite_reg  <= 1'b0;
      ex_memread_reg   <= 1'b0;
      ex_src_reg       <= '0;
      ex_uses_reg      <= '0;
      ex_bubble_reg    <= 1'b1;
      mem_dest_reg     <= '0;
      mem_regwrite_reg <= 1'b0;
      wb_dest_reg      <= '0;
      wb_regwrite_reg  <= 1'b0;
    end else begin
      wb_dest_reg      <= mem_dest_reg;
      wb_regwrite_reg  <= mem_regwrite_reg;
      mem_dest_reg     <= ex_dest_reg;
      mem_regwrite_reg <= ex_regwrite_reg;
      ex_dest_reg      <= IdDest;
      ex_src_reg       <= id_src;
      if (ex_load_bubble) begin
        ex_regwrite_reg <= 1'b0;
        ex_memread_reg  <= 1'b0;
        ex_uses_reg     <= '0;
        ex_bubble_reg   <= 1'b1;
      end else begin
        ex_regwrite_reg <= IdRegWrite;
        ex_memread_reg  <= IdMemRead;
        ex_uses_reg     <= id_uses;
        ex_bubble_reg   <= 1'b0;
      end
    end
  end

  // Saturating count of stalled cycles since reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_reg <= '0;
    end else if (Stall && (stall_cnt_reg != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule
